// File: rtl/seg_link_pkg.sv
// Shared constants, receiver state type and the segment-to-hex decoder
// for the 7-segment serial display link.
package seg_link_pkg;

    localparam int FRAME_BITS = 64;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns g..a for hex digits 0..F
    localparam logic [6:0] SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DECODE
    } rx_state_t;

    // Returns {ok, blank, nibble}; unknown patterns give all zeros
    function automatic logic [5:0] seg2hex(input logic [6:0] bits);
        logic [5:0] res;
        res = 6'b00_0000;
        if (bits == SEG_BLANK) begin
            res = 6'b11_0000;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (bits == SEG_CODE[i]) begin
                    res = {2'b10, 4'(i)};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_frame_rx_if.sv
// The four wires of the serial display link, as driven by the transmitter.
interface seg_frame_rx_if;

    logic seg_clk;
    logic seg_sout;
    logic seg_pen;
    logic seg_clrn;

    modport master (
        output seg_clk,
        output seg_sout,
        output seg_pen,
        output seg_clrn
    );

    modport slave (
        input seg_clk,
        input seg_sout,
        input seg_pen,
        input seg_clrn
    );

endinterface

// File: rtl/seg_link_sync.sv
// Multi-stage synchroniser for one link wire, with edge detection on the
// synchronised copy.
module seg_link_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ff <= '0;
            prev    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
            prev    <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign level = sync_ff[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/seg_frame_rx.sv
// Receive end of the 7-segment serial link: rebuilds the 64-bit frame and
// decodes each byte to nibble, decimal point and blank flag.
//
// state     | meaning
// ST_IDLE   | waiting for the first seg_clk rise of a frame
// ST_SHIFT  | shifting bits in on each seg_clk rise, until seg_pen rises
// ST_LATCH  | accept the frame if exactly 64 bits arrived, else reject
// ST_DECODE | decode the latched frame and pulse frame_valid
module seg_frame_rx
    import seg_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_frame_rx_if.slave         link,
    output logic [FRAME_BITS-1:0] frame,
    output logic [31:0]           hexs,
    output logic [7:0]            point,
    output logic [7:0]            blank,
    output logic [7:0]            code_ok,
    output logic                  frame_valid,
    output logic                  frame_err
);

    localparam logic [6:0] CNT_FULL = 7'(FRAME_BITS);
    localparam logic [6:0] CNT_OVF  = 7'(FRAME_BITS + 1);

    logic clk_lvl, clk_rise, clk_fall;
    logic sout_lvl, sout_rise, sout_fall;
    logic pen_lvl, pen_rise, pen_fall;
    logic clrn_lvl, clrn_rise, clrn_fall;

    seg_link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .rst(rst), .din(link.seg_clk),
        .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
    );
    seg_link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sout (
        .clk(clk), .rst(rst), .din(link.seg_sout),
        .level(sout_lvl), .rise(sout_rise), .fall(sout_fall)
    );
    seg_link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pen (
        .clk(clk), .rst(rst), .din(link.seg_pen),
        .level(pen_lvl), .rise(pen_rise), .fall(pen_fall)
    );
    seg_link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clrn (
        .clk(clk), .rst(rst), .din(link.seg_clrn),
        .level(clrn_lvl), .rise(clrn_rise), .fall(clrn_fall)
    );

    rx_state_t             state, state_nxt;
    logic [FRAME_BITS-1:0] sr;
    logic [6:0]            bit_cnt;
    logic                  do_clear, do_shift, do_latch, do_decode, cnt_clr, err_nxt;

    // Link clear has priority over every other event, including a pen rise
    always_comb begin
        state_nxt = state;
        do_clear  = 1'b0;
        do_shift  = 1'b0;
        do_latch  = 1'b0;
        do_decode = 1'b0;
        cnt_clr   = 1'b0;
        err_nxt   = 1'b0;
        if (!clrn_lvl) begin
            do_clear  = 1'b1;
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pen_rise) begin
                        err_nxt = 1'b1;
                    end else if (clk_rise) begin
                        do_shift  = 1'b1;
                        state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (pen_rise) begin
                        state_nxt = ST_LATCH;
                    end else if (clk_rise) begin
                        do_shift = 1'b1;
                    end
                end
                ST_LATCH: begin
                    cnt_clr = 1'b1;
                    if (bit_cnt == CNT_FULL) begin
                        do_latch  = 1'b1;
                        state_nxt = ST_DECODE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_DECODE: begin
                    do_decode = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    logic [31:0] dec_hexs;
    logic [7:0]  dec_point, dec_blank, dec_ok;
    logic [5:0]  dec_res;

    always_comb begin
        dec_hexs  = '0;
        dec_point = '0;
        dec_blank = '0;
        dec_ok    = '0;
        dec_res   = '0;
        for (int i = 0; i < 8; i++) begin
            dec_res             = seg2hex(frame[8*i +: 7]);
            dec_hexs[4*i +: 4]  = dec_res[3:0];
            dec_blank[i]        = dec_res[4];
            dec_ok[i]           = dec_res[5];
            dec_point[i]        = ~frame[8*i + 7];
        end
    end

    // Count saturates one past a full frame so overflow is never mistaken for 64
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (do_clear) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (cnt_clr) begin
            bit_cnt <= '0;
        end else if (do_shift) begin
            sr <= {sr[FRAME_BITS-2:0], sout_lvl};
            if (bit_cnt != CNT_OVF) begin
                bit_cnt <= bit_cnt + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame       <= '0;
            hexs        <= '0;
            point       <= '0;
            blank       <= '0;
            code_ok     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= do_decode;
            frame_err   <= err_nxt;
            if (do_latch) begin
                frame <= sr;
            end
            if (do_decode) begin
                hexs    <= dec_hexs;
                point   <= dec_point;
                blank   <= dec_blank;
                code_ok <= dec_ok;
            end
        end
    end

endmodule
